// File: rtl/lpddr_refresh_sched.sv
// Refresh scheduler between the AXI master and RAM: counts tREFI, blocks new
// AW/AR handshakes, drains outstanding bursts, then holds a tRFC refresh window.
`timescale 1ns/1ps
module lpddr_refresh_sched #(
  parameter int TREFI_W = 16,
  parameter int TRFC_W  = 8,
  parameter int OST_W   = 4,
  parameter int PEND_W  = 3,
  parameter int CNT_W   = 16
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               cfg_en,
  input  logic [TREFI_W-1:0] cfg_trefi,
  input  logic [TRFC_W-1:0]  cfg_trfc,
  input  logic               s_awvalid,
  output logic               s_awready,
  output logic               m_awvalid,
  input  logic               m_awready,
  input  logic               s_arvalid,
  output logic               s_arready,
  output logic               m_arvalid,
  input  logic               m_arready,
  input  logic               bvalid,
  input  logic               bready,
  input  logic               rvalid,
  input  logic               rready,
  input  logic               rlast,
  output logic               ref_busy,
  output logic               ref_done,
  output logic [CNT_W-1:0]   ref_count,
  output logic               ref_ovf
);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_REFRESH} state_t;

  state_t              state, state_nxt;
  logic [TREFI_W-1:0]  ivl, trefi_q, lim;
  logic [PEND_W-1:0]   pend, pend_nxt;
  logic [TRFC_W-1:0]   win, trfc_ld;
  logic [OST_W-1:0]    wr_ost, rd_ost;
  logic                aw_hold, ar_hold;
  logic                allow, run, expire, ovf_set, win_done;
  logic                aw_hs, ar_hs, b_hs, r_hs;

  always_comb begin
    allow     = (state == S_IDLE);
    m_awvalid = s_awvalid & (allow | aw_hold);
    s_awready = m_awready & (allow | aw_hold);
    m_arvalid = s_arvalid & (allow | ar_hold);
    s_arready = m_arready & (allow | ar_hold);
    aw_hs     = m_awvalid & m_awready;
    ar_hs     = m_arvalid & m_arready;
    b_hs      = bvalid & bready;
    r_hs      = rvalid & rready & rlast;
    run       = cfg_en && (cfg_trefi != '0);
    // trefi_q is the interval latched at the last reload; before the first
    // reload it is 0 and the live config is used instead.
    lim       = (trefi_q == '0) ? cfg_trefi : trefi_q;
    expire    = run && (ivl == lim - TREFI_W'(1));
    win_done  = (state == S_REFRESH) && (win == '0);
    trfc_ld   = (cfg_trfc == '0) ? '0 : cfg_trfc - TRFC_W'(1);
  end

  always_comb begin
    pend_nxt = pend;
    ovf_set  = 1'b0;
    if (expire && !win_done) begin
      if (pend == '1) ovf_set = 1'b1;
      else            pend_nxt = pend + PEND_W'(1);
    end else if (!expire && win_done) begin
      pend_nxt = pend - PEND_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (pend != '0) state_nxt = S_DRAIN;
      S_DRAIN:   if (wr_ost == '0 && rd_ost == '0 && !aw_hold && !ar_hold)
                   state_nxt = S_REFRESH;
      S_REFRESH: if (win == '0) state_nxt = (pend_nxt != '0) ? S_DRAIN : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= S_IDLE;
      ref_busy  <= 1'b0;
      ref_done  <= 1'b0;
      ref_count <= '0;
      win       <= '0;
    end else begin
      state     <= state_nxt;
      ref_busy  <= (state_nxt != S_IDLE);
      ref_done  <= win_done;
      if (win_done) ref_count <= ref_count + CNT_W'(1);
      if (state == S_DRAIN && state_nxt == S_REFRESH) win <= trfc_ld;
      else if (state == S_REFRESH && win != '0)       win <= win - TRFC_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ivl     <= '0;
      trefi_q <= '0;
      pend    <= '0;
      ref_ovf <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (ovf_set) ref_ovf <= 1'b1;
      if (!run) begin
        ivl     <= '0;
        trefi_q <= cfg_trefi;
      end else if (expire) begin
        ivl     <= '0;
        trefi_q <= cfg_trefi;
      end else begin
        ivl <= ivl + TREFI_W'(1);
        if (trefi_q == '0) trefi_q <= cfg_trefi;
      end
    end
  end

  // An address already offered downstream stays offered until accepted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_hold <= 1'b0;
      ar_hold <= 1'b0;
      wr_ost  <= '0;
      rd_ost  <= '0;
    end else begin
      if (aw_hs)                         aw_hold <= 1'b0;
      else if (m_awvalid && !m_awready)  aw_hold <= 1'b1;
      if (ar_hs)                         ar_hold <= 1'b0;
      else if (m_arvalid && !m_arready)  ar_hold <= 1'b1;
      case ({aw_hs, b_hs})
        2'b10:   wr_ost <= wr_ost + OST_W'(1);
        2'b01:   wr_ost <= wr_ost - OST_W'(1);
        default: wr_ost <= wr_ost;
      endcase
      case ({ar_hs, r_hs})
        2'b10:   rd_ost <= rd_ost + OST_W'(1);
        2'b01:   rd_ost <= rd_ost - OST_W'(1);
        default: rd_ost <= rd_ost;
      endcase
    end
  end

endmodule

// File: tb/tb_lpddr_refresh_sched.sv
// Directed bench for lpddr_refresh_sched; expected ref_done events are queued
// by the stimulus and checked by an independent monitor.
`timescale 1ns/1ps
module tb_lpddr_refresh_sched;

  logic        aclk, aresetn, cfg_en;
  logic [15:0] cfg_trefi;
  logic [7:0]  cfg_trfc;
  logic        s_awvalid, s_awready, m_awvalid, m_awready;
  logic        s_arvalid, s_arready, m_arvalid, m_arready;
  logic        bvalid, bready, rvalid, rready, rlast;
  logic        ref_busy, ref_done, ref_ovf;
  logic [15:0] ref_count;

  lpddr_refresh_sched #(.TREFI_W(16), .TRFC_W(8), .OST_W(4), .PEND_W(3), .CNT_W(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_en(cfg_en), .cfg_trefi(cfg_trefi),
    .cfg_trfc(cfg_trfc), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .s_arvalid(s_arvalid),
    .s_arready(s_arready), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .bvalid(bvalid), .bready(bready), .rvalid(rvalid), .rready(rready),
    .rlast(rlast), .ref_busy(ref_busy), .ref_done(ref_done),
    .ref_count(ref_count), .ref_ovf(ref_ovf)
  );

  typedef struct { int cnt; int edg; int blen; } exp_t;
  exp_t sbq[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   cyc;
  int   busy_run = 0;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // cyc == k between posedge k and posedge k+1 after reset release
  always @(posedge aclk or negedge aresetn)
    if (!aresetn) cyc <= 0;
    else          cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge aclk) begin
    if (aresetn) begin
      if (ref_done) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_unexpected: got ref_done at cycle %0d expected none", cyc);
        end else begin
          e = sbq.pop_front();
          chk("done_count", ref_count, e.cnt);
          chk("done_cycle", cyc, e.edg);
          if (e.blen != 0) chk("busy_len", busy_run, e.blen);
        end
        busy_run = ref_busy ? 1 : 0;
      end else if (ref_busy) busy_run++;
      else busy_run = 0;
    end else busy_run = 0;
  end

  task automatic goto(input int k);
    while (cyc < k) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic push(input int cnt, input int edg, input int blen);
    exp_t x;
    x.cnt = cnt; x.edg = edg; x.blen = blen;
    sbq.push_back(x);
  endtask

  task automatic do_reset(input logic en, input int trefi, input int trfc);
    aresetn = 1'b0;
    cfg_en = en; cfg_trefi = 16'(trefi); cfg_trfc = 8'(trfc);
    s_awvalid = 0; m_awready = 1; s_arvalid = 0; m_arready = 1;
    bvalid = 0; bready = 1; rvalid = 0; rready = 1; rlast = 0;
    sbq.delete();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  initial begin
    // periodic refresh, no traffic
    do_reset(1, 100, 10);
    chk("rst_busy", ref_busy, 0);
    chk("rst_done", ref_done, 0);
    chk("rst_count", ref_count, 0);
    chk("rst_ovf", ref_ovf, 0);
    chk("rst_awready", s_awready, 1);
    for (int n = 0; n < 10; n++) push(n + 1, 112 + 100 * n, 11);
    goto(1020); #2;
    chk("t1_count", ref_count, 10);
    chk("t1_ovf", ref_ovf, 0);
    chk("t1_sb_empty", sbq.size(), 0);

    // write outstanding at expiry, B returned 20 cycles later
    do_reset(1, 100, 10);
    push(1, 131, 30);
    goto(98);  s_awvalid = 1; #2 chk("t2_pass_idle", m_awvalid, 1);
    goto(99);  s_awvalid = 0;
    goto(105); s_awvalid = 1; #2;
    chk("t2_block_drain_v", m_awvalid, 0);
    chk("t2_block_drain_r", s_awready, 0);
    goto(119); bvalid = 1;
    goto(120); bvalid = 0;
    goto(125); #2 chk("t2_block_refresh", m_awvalid, 0);
    goto(131); #2 chk("t2_release", m_awvalid, 1);
    goto(132); s_awvalid = 0;
    goto(140); chk("t2_sb_empty", sbq.size(), 0);

    // stalled AW across DRAIN entry stays presented
    do_reset(1, 100, 10);
    push(1, 121, 20);
    goto(97);  s_awvalid = 1; m_awready = 0;
    goto(101); #2 chk("t3_hold_drain", m_awvalid, 1);
    goto(104); m_awready = 1;
    goto(105); s_awvalid = 0; #2 chk("t3_after_hs", m_awvalid, 0);
    goto(109); bvalid = 1;
    goto(110); bvalid = 0;
    goto(125); chk("t3_sb_empty", sbq.size(), 0);

    // 8-beat read burst outstanding at expiry
    do_reset(1, 100, 10);
    push(1, 128, 27);
    goto(94);  s_arvalid = 1;
    goto(95);  s_arvalid = 0;
    goto(109); rvalid = 1;
    goto(116); rlast = 1; #2 chk("t4_still_busy", ref_busy, 1);
    goto(117); rvalid = 0; rlast = 0;
    goto(135); chk("t4_sb_empty", sbq.size(), 0);

    // pending saturation, overflow, back-to-back, cfg_en drop
    do_reset(1, 4, 20);
    for (int k = 0; k < 10; k++) push(k + 1, 26 + 21 * k, 0);
    goto(35); #2 chk("t5_ovf_before", ref_ovf, 0);
    goto(36); #2 chk("t5_ovf_set", ref_ovf, 1);
    goto(70); cfg_en = 0;
    goto(230); #2;
    chk("t5_count", ref_count, 10);
    chk("t5_idle", ref_busy, 0);
    chk("t5_ovf_sticky", ref_ovf, 1);
    chk("t5_sb_empty", sbq.size(), 0);

    // async reset in the middle of a refresh window
    do_reset(1, 100, 10);
    push(1, 112, 11);
    goto(205); s_awvalid = 1; #2;
    chk("t6_block", m_awvalid, 0);
    chk("t6_busy", ref_busy, 1);
    chk("t6_sb_empty", sbq.size(), 0);
    #1 aresetn = 0;
    #1;
    chk("t6_rst_busy", ref_busy, 0);
    chk("t6_rst_done", ref_done, 0);
    chk("t6_rst_count", ref_count, 0);
    chk("t6_rst_ovf", ref_ovf, 0);
    chk("t6_rst_awvalid", m_awvalid, 1);
    chk("t6_rst_awready", s_awready, 1);
    @(negedge aclk); aresetn = 1;
    goto(3); #2;
    chk("t6_free_awready", s_awready, 1);
    chk("t6_free_count", ref_count, 0);
    s_awvalid = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
